// File: rtl/audio_mixer.sv
// Stereo mixer for SuperSprite, Mockingboard and speaker audio: per-source gain, sequenced MAC, saturation.
// Define AUDIO_MIXER_SPK_DECAY_EN to fade an idle speaker level towards zero.
module audio_mixer #(
    parameter int unsigned SPK_SHIFT    = 13,
    parameter int unsigned MB_SHIFT     = 5,
    parameter int unsigned DECAY_CYCLES = 2_700_000
) (
    input  logic        clk_logic,
    input  logic        device_reset_n,
    input  logic        sample_req_i,
    input  logic [15:0] ssp_audio_i,
    input  logic [9:0]  mb_audio_l_i,
    input  logic [9:0]  mb_audio_r_i,
    input  logic        speaker_i,
    input  logic        mute_i,
    input  logic        vol_wr_i,
    input  logic [1:0]  vol_sel_i,
    input  logic [3:0]  vol_data_i,
    output logic [15:0] audio_l_o,
    output logic [15:0] audio_r_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ACC_SSP = 3'd1;
    localparam logic [2:0] ACC_MB  = 3'd2;
    localparam logic [2:0] ACC_SPK = 3'd3;
    localparam logic [2:0] SAT     = 3'd4;

    logic [2:0]  state;
    logic [3:0]  g_ssp, g_mb, g_spk;
    logic [3:0]  sh_g_ssp, sh_g_mb, sh_g_spk;
    logic [15:0] sh_ssp;
    logic [9:0]  sh_mb_l, sh_mb_r;
    logic [15:0] sh_spk;
    logic        sh_mute;
    logic [19:0] acc_l, acc_r;
    logic [19:0] add_l, add_r;
    logic [19:0] ssp_prod, mb_l_prod, mb_r_prod, spk_prod;
    logic [15:0] sat_l, sat_r;
    logic [15:0] spk_lvl;

`ifdef AUDIO_MIXER_SPK_DECAY_EN
    logic        spk_prev;
    logic [21:0] decay_cnt;
    logic [11:0] decay_pre;

    // After DECAY_CYCLES without a speaker edge, halve the level every 4096 cycles.
    always_ff @(posedge clk_logic) begin
        if (!device_reset_n) begin
            spk_prev  <= 1'b0;
            decay_cnt <= '0;
            decay_pre <= '0;
            spk_lvl   <= '0;
        end else if (speaker_i != spk_prev) begin
            spk_prev  <= speaker_i;
            decay_cnt <= '0;
            decay_pre <= '0;
            spk_lvl   <= 16'(speaker_i) << SPK_SHIFT;
        end else if (decay_cnt != 22'(DECAY_CYCLES)) begin
            decay_cnt <= decay_cnt + 22'd1;
        end else begin
            decay_pre <= decay_pre + 12'd1;
            if (decay_pre == '1) begin
                spk_lvl <= spk_lvl >> 1;
            end
        end
    end
`else
    assign spk_lvl = 16'(speaker_i) << SPK_SHIFT;
`endif

    assign ssp_prod  = 20'(sh_ssp) * 20'(sh_g_ssp);
    assign mb_l_prod = (20'(sh_mb_l) << MB_SHIFT) * 20'(sh_g_mb);
    assign mb_r_prod = (20'(sh_mb_r) << MB_SHIFT) * 20'(sh_g_mb);
    assign spk_prod  = 20'(sh_spk) * 20'(sh_g_spk);

    always_comb begin
        add_l = '0;
        add_r = '0;
        case (state)
            ACC_SSP: begin
                add_l = ssp_prod >> 3;
                add_r = ssp_prod >> 3;
            end
            ACC_MB: begin
                add_l = mb_l_prod >> 3;
                add_r = mb_r_prod >> 3;
            end
            ACC_SPK: begin
                add_l = spk_prod >> 3;
                add_r = spk_prod >> 3;
            end
            default: ;
        endcase
    end

    always_comb begin
        sat_l = (acc_l > 20'h0FFFF) ? 16'hFFFF : acc_l[15:0];
        sat_r = (acc_r > 20'h0FFFF) ? 16'hFFFF : acc_r[15:0];
        if (sh_mute) begin
            sat_l = '0;
            sat_r = '0;
        end
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_logic) begin
        if (!device_reset_n) begin
            state     <= IDLE;
            audio_l_o <= '0;
            audio_r_o <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
            g_ssp     <= 4'd8;
            g_mb      <= 4'd8;
            g_spk     <= 4'd8;
            sh_g_ssp  <= '0;
            sh_g_mb   <= '0;
            sh_g_spk  <= '0;
            sh_ssp    <= '0;
            sh_mb_l   <= '0;
            sh_mb_r   <= '0;
            sh_spk    <= '0;
            sh_mute   <= 1'b0;
            acc_l     <= '0;
            acc_r     <= '0;
        end else begin
            valid_o   <= 1'b0;
            overrun_o <= sample_req_i && (state != IDLE);

            if (vol_wr_i) begin
                case (vol_sel_i)
                    2'd0:    g_ssp <= vol_data_i;
                    2'd1:    g_mb  <= vol_data_i;
                    2'd2:    g_spk <= vol_data_i;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (sample_req_i) begin
                        sh_ssp   <= ssp_audio_i;
                        sh_mb_l  <= mb_audio_l_i;
                        sh_mb_r  <= mb_audio_r_i;
                        sh_spk   <= spk_lvl;
                        sh_mute  <= mute_i;
                        sh_g_ssp <= g_ssp;
                        sh_g_mb  <= g_mb;
                        sh_g_spk <= g_spk;
                        acc_l    <= '0;
                        acc_r    <= '0;
                        state    <= ACC_SSP;
                    end
                end
                ACC_SSP, ACC_MB, ACC_SPK: begin
                    acc_l <= acc_l + add_l;
                    acc_r <= acc_r + add_r;
                    state <= state + 3'd1;
                end
                SAT: begin
                    audio_l_o <= sat_l;
                    audio_r_o <= sat_r;
                    valid_o   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: a driver predicts samples/overruns, a monitor checks them on output.
`timescale 1ns/1ps
module tb_audio_mixer;

`ifdef AUDIO_MIXER_SPK_DECAY_EN
    localparam int unsigned TB_DECAY = 100;
`else
    localparam int unsigned TB_DECAY = 2_700_000;
`endif

    logic        clk = 1'b0;
    logic        device_reset_n = 1'b0;
    logic        sample_req_i = 1'b0;
    logic [15:0] ssp_audio_i = '0;
    logic [9:0]  mb_audio_l_i = '0;
    logic [9:0]  mb_audio_r_i = '0;
    logic        speaker_i = 1'b0;
    logic        mute_i = 1'b0;
    logic        vol_wr_i = 1'b0;
    logic [1:0]  vol_sel_i = '0;
    logic [3:0]  vol_data_i = '0;
    logic [15:0] audio_l_o, audio_r_o;
    logic        valid_o, busy_o, overrun_o;

    audio_mixer #(.SPK_SHIFT(13), .MB_SHIFT(5), .DECAY_CYCLES(TB_DECAY)) dut (
        .clk_logic(clk), .device_reset_n(device_reset_n), .sample_req_i(sample_req_i),
        .ssp_audio_i(ssp_audio_i), .mb_audio_l_i(mb_audio_l_i), .mb_audio_r_i(mb_audio_r_i),
        .speaker_i(speaker_i), .mute_i(mute_i), .vol_wr_i(vol_wr_i), .vol_sel_i(vol_sel_i),
        .vol_data_i(vol_data_i), .audio_l_o(audio_l_o), .audio_r_o(audio_r_o),
        .valid_o(valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          stamp;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   g_model[3] = '{8, 8, 8};
    int   last_accept = -100;
    int   last_edge = 0;
    int   spk_model = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: gain is value/8, sources summed then clipped to 16 bits.
    function automatic logic [15:0] mix(input int ssp, input int mb, input int spk_term,
                                        input int gs, input int gm, input int gk, input bit mute);
        int s;
        s = (ssp * gs) / 8 + (mb * 32 * gm) / 8 + (spk_term * gk) / 8;
        if (mute) return 16'h0000;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    task automatic step(input bit req, input logic [15:0] ssp, input logic [9:0] ml,
                        input logic [9:0] mr, input bit spk, input bit mute, input bit wr,
                        input logic [1:0] sel, input logic [3:0] data);
        int   e;
        int   st;
        exp_t x;
        @(negedge clk);
        device_reset_n = 1'b1;
        sample_req_i   = req;
        ssp_audio_i    = ssp;
        mb_audio_l_i   = ml;
        mb_audio_r_i   = mr;
        speaker_i      = spk;
        mute_i         = mute;
        vol_wr_i       = wr;
        vol_sel_i      = sel;
        vol_data_i     = data;
        e = cyc + 1;
        last_edge = e;
        if (req) begin
            if (e >= last_accept + 5) begin
                st = (spk_model >= 0) ? spk_model : (spk ? 8192 : 0);
                x.stamp = e + 4;
                x.l = mix(ssp, ml, st, g_model[0], g_model[1], g_model[2], mute);
                x.r = mix(ssp, mr, st, g_model[0], g_model[1], g_model[2], mute);
                exp_q.push_back(x);
                last_accept = e;
            end else begin
                ovr_q.push_back(e);
            end
        end
        if (wr && sel != 2'd3) g_model[sel] = data;
    endtask

    task automatic idle(input int n, input bit spk);
        repeat (n) step(0, '0, '0, '0, spk, 0, 0, 2'd0, 4'd0);
    endtask

    task automatic do_reset();
        int e;
        @(negedge clk);
        device_reset_n = 1'b0;
        sample_req_i   = 1'b0;
        vol_wr_i       = 1'b0;
        e = cyc + 1;
        while (exp_q.size() > 0 && exp_q[$].stamp >= e) void'(exp_q.pop_back());
        while (ovr_q.size() > 0 && ovr_q[$] >= e) void'(ovr_q.pop_back());
        g_model = '{8, 8, 8};
        last_accept = -100;
        @(negedge clk);
        check("reset_l", audio_l_o, 0);
        check("reset_r", audio_r_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_overrun", overrun_o, 0);
        device_reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            check("valid_timing", valid_o, 1);
            if (valid_o) begin
                check("audio_l", audio_l_o, exp_q[0].l);
                check("audio_r", audio_r_o, exp_q[0].r);
            end
            void'(exp_q.pop_front());
        end else if (valid_o) begin
            check("unexpected_valid", valid_o, 0);
        end
        if (ovr_q.size() > 0 && ovr_q[0] <= cyc) begin
            check("overrun_pulse", overrun_o, 1);
            void'(ovr_q.pop_front());
        end else if (overrun_o) begin
            check("unexpected_overrun", overrun_o, 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ec;
        do_reset();
`ifdef AUDIO_MIXER_SPK_DECAY_EN
        step(0, '0, '0, '0, 1, 0, 0, 2'd0, 4'd0);
        ec = last_edge;
        for (int k = -1; k <= 14; k++) begin
            int target;
            target = (k < 0) ? ec + 50 : ec + int'(TB_DECAY) + k * 4096 + 2048;
            while (last_edge + 1 < target) idle(1, 1);
            spk_model = (k < 0) ? 8192 : (8192 >> k);
            step(1, '0, '0, '0, 1, 0, 0, 2'd0, 4'd0);
            spk_model = -1;
        end
        idle(6, 1);
        idle(1, 0);
        spk_model = 0;
        step(1, '0, '0, '0, 0, 0, 0, 2'd0, 4'd0);
        idle(6, 0);
        idle(1, 1);
        spk_model = 8192;
        step(1, '0, '0, '0, 1, 0, 0, 2'd0, 4'd0);
        spk_model = -1;
        idle(8, 1);
`else
        step(1, 16'h1000, 10'h010, 10'h010, 1, 0, 0, 2'd0, 4'd0);
        idle(5, 0);
        step(0, '0, '0, '0, 0, 0, 1, 2'd0, 4'd15);
        step(1, 16'hFFFF, 10'h3FF, 10'h3FF, 0, 0, 0, 2'd0, 4'd0);
        idle(5, 0);
        step(0, '0, '0, '0, 0, 0, 1, 2'd0, 4'd0);
        step(1, 16'hFFFF, '0, '0, 0, 0, 0, 2'd0, 4'd0);
        idle(5, 0);
        step(0, '0, '0, '0, 0, 0, 1, 2'd0, 4'd8);
        step(1, '0, 10'h3FF, '0, 0, 0, 0, 2'd0, 4'd0);
        idle(5, 0);
        step(1, '0, 10'h3FF, '0, 0, 1, 0, 2'd0, 4'd0);
        idle(5, 0);
        // overrun while busy; ssp changes after accept must not leak in
        step(1, 16'h1234, '0, '0, 0, 0, 0, 2'd0, 4'd0);
        step(0, 16'hABCD, '0, '0, 0, 0, 1, 2'd0, 4'd3);
        step(1, 16'h5555, '0, '0, 0, 0, 0, 2'd0, 4'd0);
        idle(5, 0);
        step(0, '0, '0, '0, 0, 0, 1, 2'd1, 4'd3);
        step(1, 16'h1000, 10'h010, 10'h010, 1, 0, 0, 2'd0, 4'd0);
        idle(2, 0);
        do_reset();
        step(1, 16'h1000, 10'h010, 10'h010, 1, 0, 0, 2'd0, 4'd0);
        idle(5, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 2) == 0, 16'($urandom), 10'($urandom), 10'($urandom),
                     1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                     2'($urandom), 4'($urandom));
            end
        end
        idle(8, 0);
`endif
        check("drain", exp_q.size() + ovr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
